pipeline_if_stage: RTL and testbench

//  Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
//  - Owns the PC and drives the combinational instruction-memory read.
//  - Presents pc_4/inst to IF/ID and applies redirects: jumps resolved in ID, branches resolved in EX.
//  - Emits the flush requests for IF/ID and ID/EX; tracks halt/resume; counts fetches.

---
 rtl/pipeline_if_stage_if.sv | 41 ++++
 rtl/pipeline_if_stage.sv | 112 +++++++++++
 tb/tb_pipeline_if_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_if_stage_if.sv
// Bundle of the fetch stage's signals.
// The master modport is the fetch stage itself. The slave modport is the
// surrounding pipeline: the hazard unit, the ID/EX redirect sources, the
// halt logic, IF/ID and the instruction memory.
interface pipeline_if_stage_if #(
    parameter int IM_ADDR_BIT = 10
);
    // Control and redirects driven into the fetch stage
    logic                   en;
    logic                   id_jump_en;
    logic [31:0]            id_jump_target;
    logic                   ex_branch_en;
    logic [31:0]            ex_branch_target;
    logic                   halt;
    logic                   resume;

    // Instruction-memory read path (combinational)
    logic [31:0]            im_data;
    logic [IM_ADDR_BIT-1:0] im_addr;

    // Outputs towards IF/ID, the flush network and status
    logic [31:0]            pc;
    logic [31:0]            pc_4;
    logic [31:0]            inst;
    logic                   flush_if_id;
    logic                   flush_id_ex;
    logic                   halted;
    logic [31:0]            fetch_cnt;

    modport master (
        input  en, id_jump_en, id_jump_target, ex_branch_en, ex_branch_target,
        input  halt, resume, im_data,
        output im_addr, pc, pc_4, inst, flush_if_id, flush_id_ex, halted, fetch_cnt
    );

    modport slave (
        output en, id_jump_en, id_jump_target, ex_branch_en, ex_branch_target,
        output halt, resume, im_data,
        input  im_addr, pc, pc_4, inst, flush_if_id, flush_id_ex, halted, fetch_cnt
    );
endinterface

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage.
// Owns the PC, reads the instruction memory combinationally and applies
// redirects: a branch from EX outranks a jump from ID, which outranks
// sequential fetch. It also drives the IF/ID and ID/EX flushes, tracks the
// RUN/HALTED state and counts PC updates.
module pipeline_if_stage #(
    parameter int          IM_ADDR_BIT = 10,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,    // asynchronous, active-low
    pipeline_if_stage_if.master  bus
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // The low two bits of the reset PC are cleared so the PC stays word aligned.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        pc_move;
    logic        flush_if_id_c;
    logic        flush_id_ex_c;

    // The sum wraps naturally at 32 bits, so 0xFFFF_FFFC + 4 gives 0.
    assign pc_plus4 = pc_q + 32'd4;

    // State, PC and fetch-counter registers.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC_ALIGNED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select the next state and next PC, and raise the flushes. The redirect
    // priority is: branch, then jump (only while not stalled), then pc+4.
    // NOTE: every output of this block gets a default first. Without the
    // defaults, any path that skips an assignment would infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        target        = pc_q;
        pc_move       = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.ex_branch_en) begin
                    target        = {bus.ex_branch_target[31:2], 2'b00};
                    pc_move       = 1'b1;
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                end else if (bus.id_jump_en && bus.en) begin
                    target        = {bus.id_jump_target[31:2], 2'b00};
                    pc_move       = 1'b1;
                    flush_if_id_c = 1'b1;
                end else if (bus.en) begin
                    target        = pc_plus4;
                    pc_move       = 1'b1;
                end

                // A halt wins over the PC update. The flushes still go out,
                // so the younger instructions are killed.
                if (bus.halt) begin
                    state_d = ST_HALTED;
                end else if (pc_move) begin
                    pc_d  = target;
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_HALTED: begin
                if (bus.resume && !bus.halt) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output drive. While reset is asserted, inst and the flushes are gated to
    // 0. The state register already forces halted and fetch_cnt to 0.
    assign bus.im_addr     = pc_q[IM_ADDR_BIT+1:2];
    assign bus.pc          = pc_q;
    assign bus.pc_4        = pc_plus4;
    assign bus.inst        = (rst && state_q == ST_RUN) ? bus.im_data : 32'h0;
    assign bus.flush_if_id = rst & flush_if_id_c;
    assign bus.flush_id_ex = rst & flush_id_ex_c;
    assign bus.halted      = (state_q == ST_HALTED);
    assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Self-checking bench for pipeline_if_stage.
// The reference model keeps an abstract view of the stage: the current
// fetch address, whether fetching is halted, and how many fetches have
// happened. It derives every expected output from those values.
module tb_pipeline_if_stage;

    localparam int          AW     = 10;
    localparam logic [31:0] RST_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pipeline_if_stage_if #(.IM_ADDR_BIT(AW)) bus  ();
    pipeline_if_stage_if #(.IM_ADDR_BIT(AW)) bus2 ();

    pipeline_if_stage #(.IM_ADDR_BIT(AW), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    pipeline_if_stage #(.IM_ADDR_BIT(AW), .RESET_PC(32'hFFFF_FFFC)) dut_top (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    // Instruction memory model
    logic [31:0] mem [0:(1<<AW)-1];
    always_comb bus.im_data = mem[bus.im_addr];

    // Reference model state
    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] m_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic en_i, input logic jmp_i, input logic [31:0] jt_i,
                         input logic br_i, input logic [31:0] bt_i,
                         input logic halt_i, input logic resume_i);
        bus.en               = en_i;
        bus.id_jump_en       = jmp_i;
        bus.id_jump_target   = jt_i;
        bus.ex_branch_en     = br_i;
        bus.ex_branch_target = bt_i;
        bus.halt             = halt_i;
        bus.resume           = resume_i;
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_halted = 1'b0;
        m_cnt    = 32'h0;
    endtask

    // Compare the combinational outputs against the model, take one clock
    // edge, then advance the model. The task starts and ends at a falling edge.
    task automatic run_cycle();
        logic        taken_br, taken_jmp, moves;
        logic [31:0] nxt, e_inst;
        #1;
        taken_br  = !m_halted && bus.ex_branch_en;
        taken_jmp = !m_halted && !bus.ex_branch_en && bus.id_jump_en && bus.en;
        moves     = !m_halted && (bus.ex_branch_en || bus.en);
        if (bus.ex_branch_en)             nxt = bus.ex_branch_target & ~32'd3;
        else if (bus.id_jump_en && bus.en) nxt = bus.id_jump_target & ~32'd3;
        else                              nxt = m_pc + 32'd4;
        e_inst = m_halted ? 32'h0 : mem[m_pc[AW+1:2]];

        check("pc",          bus.pc, m_pc);
        check("pc_4",        bus.pc_4, m_pc + 32'd4);
        check("im_addr",     32'(bus.im_addr), 32'(m_pc[AW+1:2]));
        check("inst",        bus.inst, e_inst);
        check("flush_if_id", 32'(bus.flush_if_id), 32'(taken_br || taken_jmp));
        check("flush_id_ex", 32'(bus.flush_id_ex), 32'(taken_br));
        check("halted",      32'(bus.halted), 32'(m_halted));
        check("fetch_cnt",   bus.fetch_cnt, m_cnt);

        @(posedge clk);
        if (m_halted) begin
            if (bus.resume && !bus.halt) m_halted = 1'b0;
        end else if (bus.halt) begin
            m_halted = 1'b1;
        end else if (moves) begin
            m_pc  = nxt;
            m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    // Expected values while reset is held: all zeros except the PC-derived outputs
    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},     bus.pc, RST_PC);
        check({tag, "_pc_4"},   bus.pc_4, RST_PC + 32'd4);
        check({tag, "_inst"},   bus.inst, 32'h0);
        check({tag, "_fl_ifid"}, 32'(bus.flush_if_id), 32'h0);
        check({tag, "_fl_idex"}, 32'(bus.flush_id_ex), 32'h0);
        check({tag, "_halted"}, 32'(bus.halted), 32'h0);
        check({tag, "_cnt"},    bus.fetch_cnt, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = (i < 4) ? 32'(i) : $urandom();
        bus2.en = 1'b0; bus2.id_jump_en = 1'b0; bus2.id_jump_target = 32'h0;
        bus2.ex_branch_en = 1'b0; bus2.ex_branch_target = 32'h0;
        bus2.halt = 1'b0; bus2.resume = 1'b0; bus2.im_data = 32'hDEAD_BEEF;

        // Hold reset with busy inputs; inst and the flushes must stay 0
        drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst = 1'b1;

        // T1: sequential fetch from IM[i] = i
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            run_cycle();
        end
        check("t1_pc",  bus.pc, 32'h10);
        check("t1_cnt", bus.fetch_cnt, 32'd4);

        // T2: reach pc 0x20; a jump during a stall is ignored, then taken
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            run_cycle();
        end
        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cycle();
        drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cycle();
        check("t2_pc", bus.pc, 32'h100);

        // T3: a branch beats the jump and the stall
        drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 1'b0);
        run_cycle();
        check("t3_pc", bus.pc, 32'h40);

        // T4: branch to 0x10 (misaligned target), halt with a redirect,
        // stay halted, try resume while halt is 1, then resume
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 1'b0, 1'b0);
        run_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0);
        run_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1, (i == 2));
            run_cycle();
        end
        check("t4_pc_held", bus.pc, 32'h10);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        run_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cycle();
        check("t4_pc_resumed", bus.pc, 32'h14);

        // T5: PC wrap-around on the instance reset to 0xFFFF_FFFC
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        bus2.en = 1'b1;
        #1;
        check("t5_pc",      bus2.pc, 32'hFFFF_FFFC);
        check("t5_pc_4",    bus2.pc_4, 32'h0);
        check("t5_im_addr", 32'(bus2.im_addr), 32'h3FF);
        run_cycle();
        check("t5_pc_next", bus2.pc, 32'h0);
        check("t5_cnt",     bus2.fetch_cnt, 32'd1);
        bus2.en = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic h, r;
            if (m_halted) begin
                h = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 2) == 0);
            end else begin
                h = ($urandom_range(0, 39) == 0);
                r = ($urandom_range(0, 7) == 0);
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom(),
                  $urandom_range(0, 7) == 0, $urandom(), h, r);
            run_cycle();
        end

        // T6: async reset between edges while a branch is pending
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_reset_values("t6a");
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cycle();
        // Reset while halted also clears the state immediately
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        run_cycle();
        check("t6_halted_before", 32'(bus.halted), 32'h1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_reset_values("t6b");
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cycle();
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
